i2s_stream_scheduler: RTL and testbench

- Sits between the DSP sample pipeline and the I2S transceiver.
- Buffers outbound stereo frames in a small FIFO and presents them one at a time on the transceiver's tx handshake.
- Holds each presented frame stable for the whole left+right word.
- Fills underruns with silence or the last sample, and captures inbound frames into a single-entry output register with overrun accounting. Provides run/mute control and status counters.

---
 rtl/i2s_stream_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_i2s_stream_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stream_scheduler.sv
// i2s_stream_scheduler
// Buffers outbound stereo frames for an I2S transceiver, presents them one at a time and
// holds each presented frame stable for the whole left+right word. Underruns are filled with
// silence or a repeat of the last frame. Inbound frames land in a single-entry register with
// overrun accounting.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   enable, mute                  run request (level), force transmitted samples to zero
//   in_l/in_r/in_valid/in_ready   upstream TX frame stream
//   out_l/out_r/out_valid/out_ready  received frame register
//   xcvr_tx_l/r/valid/ready       frame presented to the transceiver
//   xcvr_rx_l/r/valid/ready       received frame pulse from the transceiver
//   running                       scheduler is in RUN
//   underrun_pulse                one cycle per inserted fill frame
//   underrun_cnt, overrun_cnt     saturating fill / RX-overwrite counters
module i2s_stream_scheduler #(
    parameter int unsigned SAMPLE_BITS   = 16,
    parameter int unsigned TX_DEPTH      = 4,
    parameter int unsigned PRIME_LEVEL   = 2,
    parameter int unsigned UNDERRUN_HOLD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mute,
    input  logic signed [SAMPLE_BITS-1:0] in_l,
    input  logic signed [SAMPLE_BITS-1:0] in_r,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [SAMPLE_BITS-1:0] out_l,
    output logic signed [SAMPLE_BITS-1:0] out_r,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [SAMPLE_BITS-1:0] xcvr_tx_l,
    output logic signed [SAMPLE_BITS-1:0] xcvr_tx_r,
    output logic                          xcvr_tx_valid,
    input  logic                          xcvr_tx_ready,
    input  logic signed [SAMPLE_BITS-1:0] xcvr_rx_l,
    input  logic signed [SAMPLE_BITS-1:0] xcvr_rx_r,
    input  logic                          xcvr_rx_valid,
    output logic                          xcvr_rx_ready,
    output logic                          running,
    output logic                          underrun_pulse,
    output logic [15:0]                   underrun_cnt,
    output logic [15:0]                   overrun_cnt
);
    localparam int unsigned PtrW = $clog2(TX_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullLevel  = CntW'(TX_DEPTH);
    localparam logic [CntW-1:0] PrimeLevel = CntW'(PRIME_LEVEL);

    typedef enum logic [1:0] {StDisabled, StPrime, StRun, StDrain} state_e;
    state_e state_q, state_d;

    logic signed [SAMPLE_BITS-1:0] fifo_l [TX_DEPTH];
    logic signed [SAMPLE_BITS-1:0] fifo_r [TX_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic signed [SAMPLE_BITS-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
    logic signed [SAMPLE_BITS-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic signed [SAMPLE_BITS-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic signed [SAMPLE_BITS-1:0] head_l, head_r, src_l, src_r;
    logic act_vld_q, act_vld_d;
    logic out_valid_q, out_valid_d;
    logic underrun_pulse_q, underrun_pulse_d;
    logic [15:0] underrun_cnt_q, underrun_cnt_d, overrun_cnt_q, overrun_cnt_d;

    logic fifo_empty, fifo_full, push, pop, load, fill;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullLevel);
    assign head_l     = fifo_l[rd_ptr_q];
    assign head_r     = fifo_r[rd_ptr_q];

    assign in_ready = !fifo_full && (state_q == StPrime || state_q == StRun);
    assign push     = in_valid && in_ready;
    // Dropping enable in RUN heads to DRAIN rather than starting another frame.
    assign load     = (state_q == StRun) && enable && !act_vld_q && xcvr_tx_ready;
    assign pop      = load && !fifo_empty;
    assign fill     = load && fifo_empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDisabled: if (enable) state_d = StPrime;
            StPrime: begin
                if (!enable) state_d = StDisabled;
                else if (count_q >= PrimeLevel) state_d = StRun;
            end
            StRun: if (!enable) state_d = StDrain;
            // Leave only once the in-flight frame has been handed over and finished.
            StDrain: if (!act_vld_q && xcvr_tx_ready) state_d = StDisabled;
            default: state_d = StDisabled;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        if (state_q == StDisabled) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        src_l = '0;
        src_r = '0;
        if (pop) begin
            src_l = head_l;
            src_r = head_r;
        end else if (UNDERRUN_HOLD != 0) begin
            src_l = last_l_q;
            src_r = last_r_q;
        end

        act_l_d   = act_l_q;
        act_r_d   = act_r_q;
        act_vld_d = act_vld_q;
        last_l_d  = last_l_q;
        last_r_d  = last_r_q;
        if (xcvr_tx_valid && xcvr_tx_ready) act_vld_d = 1'b0;
        if (load) begin
            act_vld_d = 1'b1;
            act_l_d   = mute ? '0 : src_l;
            act_r_d   = mute ? '0 : src_r;
        end
        // last tracks the unmuted head so a repeat fill after unmute is audible.
        if (pop) begin
            last_l_d = head_l;
            last_r_d = head_r;
        end
        if (state_q == StDisabled) act_vld_d = 1'b0;

        underrun_pulse_d = fill;
        underrun_cnt_d   = underrun_cnt_q;
        if (fill && underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
    end

    always_comb begin
        out_l_d       = out_l_q;
        out_r_d       = out_r_q;
        out_valid_d   = out_valid_q;
        overrun_cnt_d = overrun_cnt_q;
        if (xcvr_rx_valid) begin
            if (out_valid_q && !out_ready && overrun_cnt_q != 16'hFFFF) begin
                overrun_cnt_d = overrun_cnt_q + 16'd1;
            end
            out_l_d     = xcvr_rx_l;
            out_r_d     = xcvr_rx_r;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_l[wr_ptr_q] <= in_l;
            fifo_r[wr_ptr_q] <= in_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StDisabled;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            act_l_q          <= '0;
            act_r_q          <= '0;
            act_vld_q        <= 1'b0;
            last_l_q         <= '0;
            last_r_q         <= '0;
            out_l_q          <= '0;
            out_r_q          <= '0;
            out_valid_q      <= 1'b0;
            underrun_pulse_q <= 1'b0;
            underrun_cnt_q   <= '0;
            overrun_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            act_l_q          <= act_l_d;
            act_r_q          <= act_r_d;
            act_vld_q        <= act_vld_d;
            last_l_q         <= last_l_d;
            last_r_q         <= last_r_d;
            out_l_q          <= out_l_d;
            out_r_q          <= out_r_d;
            out_valid_q      <= out_valid_d;
            underrun_pulse_q <= underrun_pulse_d;
            underrun_cnt_q   <= underrun_cnt_d;
            overrun_cnt_q    <= overrun_cnt_d;
        end
    end

    assign xcvr_tx_l      = act_l_q;
    assign xcvr_tx_r      = act_r_q;
    assign xcvr_tx_valid  = act_vld_q;
    assign xcvr_rx_ready  = (state_q != StDisabled);
    assign running        = (state_q == StRun);
    assign out_l          = out_l_q;
    assign out_r          = out_r_q;
    assign out_valid      = out_valid_q;
    assign underrun_pulse = underrun_pulse_q;
    assign underrun_cnt   = underrun_cnt_q;
    assign overrun_cnt    = overrun_cnt_q;
endmodule

// File: tb/tb_i2s_stream_scheduler.sv
// Bench for i2s_stream_scheduler: two instances (zero fill and repeat fill) share stimulus,
// each paired with a small transceiver model and a queue-based reference model.
module tb_i2s_stream_scheduler;
    localparam int Depth = 4;
    localparam int PrimeLvl = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, mute, in_valid, out_ready, rx_valid;
    logic [15:0] in_l, in_r, rx_l, rx_r;
    logic        tx_ready [2];
    logic        in_ready [2], out_valid [2], tx_valid [2], rx_ready [2];
    logic        running [2], upulse [2];
    logic [15:0] out_l [2], out_r [2], tx_l [2], tx_r [2], ucnt [2], ocnt [2];

    i2s_stream_scheduler #(.SAMPLE_BITS(16), .TX_DEPTH(Depth), .PRIME_LEVEL(PrimeLvl),
                           .UNDERRUN_HOLD(0)) u_zero (
        .clk(clk), .rst(rst), .enable(enable), .mute(mute),
        .in_l(in_l), .in_r(in_r), .in_valid(in_valid), .in_ready(in_ready[0]),
        .out_l(out_l[0]), .out_r(out_r[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .xcvr_tx_l(tx_l[0]), .xcvr_tx_r(tx_r[0]), .xcvr_tx_valid(tx_valid[0]),
        .xcvr_tx_ready(tx_ready[0]), .xcvr_rx_l(rx_l), .xcvr_rx_r(rx_r),
        .xcvr_rx_valid(rx_valid), .xcvr_rx_ready(rx_ready[0]), .running(running[0]),
        .underrun_pulse(upulse[0]), .underrun_cnt(ucnt[0]), .overrun_cnt(ocnt[0])
    );

    i2s_stream_scheduler #(.SAMPLE_BITS(16), .TX_DEPTH(Depth), .PRIME_LEVEL(PrimeLvl),
                           .UNDERRUN_HOLD(1)) u_hold (
        .clk(clk), .rst(rst), .enable(enable), .mute(mute),
        .in_l(in_l), .in_r(in_r), .in_valid(in_valid), .in_ready(in_ready[1]),
        .out_l(out_l[1]), .out_r(out_r[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .xcvr_tx_l(tx_l[1]), .xcvr_tx_r(tx_r[1]), .xcvr_tx_valid(tx_valid[1]),
        .xcvr_tx_ready(tx_ready[1]), .xcvr_rx_l(rx_l), .xcvr_rx_r(rx_r),
        .xcvr_rx_valid(rx_valid), .xcvr_rx_ready(rx_ready[1]), .running(running[1]),
        .underrun_pulse(upulse[1]), .underrun_cnt(ucnt[1]), .overrun_cnt(ocnt[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: operating mode, a queue for the FIFO, the frame on the wire.
    typedef enum int {MOff, MPrime, MRun, MDrain} mmode_e;
    mmode_e      m_mode [2];
    logic [31:0] m_fifo [2][$];
    logic [31:0] m_act [2], m_last [2], m_out [2];
    bit          m_present [2], m_oval [2], m_upulse [2];
    logic [15:0] m_ucnt [2], m_ocnt [2];

    // Transceiver model: busy for a left word then a right word after each handshake.
    int          xc_busy [2], xc_w [2];
    bit          xc_hs [2];
    bit          xc_rand_w;
    logic [15:0] xc_capl [2], xc_capr [2];
    logic [31:0] xc_log [2][$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_in_ready(int d);
        return (m_mode[d] == MPrime || m_mode[d] == MRun) && m_fifo[d].size() < Depth;
    endfunction

    function automatic logic [101:0] model_vec(int d);
        return {m_in_ready(d), m_present[d], m_act[d], m_oval[d], m_out[d],
                m_mode[d] != MOff, m_mode[d] == MRun, m_upulse[d], m_ucnt[d], m_ocnt[d]};
    endfunction

    function automatic logic [101:0] dut_vec(int d);
        return {in_ready[d], tx_valid[d], tx_l[d], tx_r[d], out_valid[d], out_l[d], out_r[d],
                rx_ready[d], running[d], upulse[d], ucnt[d], ocnt[d]};
    endfunction

    function automatic logic [31:0] log_at(int d, int i);
        if (i < xc_log[d].size()) return xc_log[d][i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset(int d);
        m_mode[d] = MOff;
        m_fifo[d].delete();
        m_act[d] = '0;
        m_last[d] = '0;
        m_out[d] = '0;
        m_present[d] = 0;
        m_oval[d] = 0;
        m_upulse[d] = 0;
        m_ucnt[d] = '0;
        m_ocnt[d] = '0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step(int d);
        int          sz;
        bit          ld, was_present, accept;
        logic [31:0] f;
        if (rst) begin
            model_reset(d);
            return;
        end
        sz = m_fifo[d].size();
        accept = in_valid && m_in_ready(d);
        was_present = m_present[d];
        ld = (m_mode[d] == MRun) && enable && !m_present[d] && tx_ready[d];
        m_upulse[d] = 0;
        if (ld) begin
            if (sz > 0) begin
                f = m_fifo[d].pop_front();
                m_last[d] = f;
            end else begin
                f = (d == 1) ? m_last[d] : 32'h0;
                m_upulse[d] = 1;
                if (m_ucnt[d] != 16'hFFFF) m_ucnt[d] = m_ucnt[d] + 16'd1;
            end
            m_act[d] = mute ? 32'h0 : f;
            m_present[d] = 1;
        end else if (m_present[d] && tx_ready[d]) begin
            m_present[d] = 0;
        end
        if (accept) m_fifo[d].push_back({in_l, in_r});
        case (m_mode[d])
            MOff: begin
                m_fifo[d].delete();
                if (enable) m_mode[d] = MPrime;
            end
            MPrime: begin
                if (!enable) m_mode[d] = MOff;
                else if (sz >= PrimeLvl) m_mode[d] = MRun;
            end
            MRun: if (!enable) m_mode[d] = MDrain;
            MDrain: if (!was_present && tx_ready[d]) m_mode[d] = MOff;
            default: m_mode[d] = MOff;
        endcase
        if (rx_valid) begin
            if (m_oval[d] && !out_ready && m_ocnt[d] != 16'hFFFF) m_ocnt[d] = m_ocnt[d] + 16'd1;
            m_out[d] = {rx_l, rx_r};
            m_oval[d] = 1;
        end else if (out_ready) begin
            m_oval[d] = 0;
        end
    endtask

    // Runs at the negative edge; decides tx_ready for the coming rising edge.
    task automatic xc_update(int d);
        if (rst) begin
            xc_busy[d] = 0;
            xc_hs[d] = 0;
            tx_ready[d] = 1'b1;
            return;
        end
        if (xc_hs[d]) begin
            xc_hs[d] = 0;
            tx_ready[d] = 1'b0;
            xc_w[d] = xc_rand_w ? int'($urandom_range(1, 3)) : 2;
            xc_busy[d] = 2 * xc_w[d];
        end else if (xc_busy[d] > 0) begin
            xc_busy[d]--;
            if (xc_busy[d] == xc_w[d]) xc_capr[d] = tx_r[d];
            if (xc_busy[d] == 0) begin
                tx_ready[d] = 1'b1;
                xc_log[d].push_back({xc_capl[d], xc_capr[d]});
            end
        end
        if (tx_ready[d] && tx_valid[d]) begin
            xc_hs[d] = 1;
            xc_capl[d] = tx_l[d];
        end
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) xc_update(d);
        for (int d = 0; d < 2; d++) model_step(d);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("cycle%0d inst%0d outputs", cyc, d), 128'(dut_vec(d)),
                  128'(model_vec(d)));
        end
    endtask

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        int i;
        i = 0;
        in_valid = 1'b0;
        while (!(m_in_ready(0) && m_in_ready(1)) && i < 50) begin
            tick();
            i++;
        end
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_logs();
        xc_log[0].delete();
        xc_log[1].delete();
    endtask

    task automatic drain_to_disabled(input string name);
        enable = 1'b0;
        for (int i = 0; i < 100 && (rx_ready[0] || rx_ready[1]); i++) tick();
        check({name, " disabled"}, {rx_ready[0], rx_ready[1], tx_valid[0], tx_valid[1]}, 0);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mute = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rx_valid = 1'b0; in_l = '0; in_r = '0; rx_l = '0; rx_r = '0; xc_rand_w = 0;
        tx_ready[0] = 1'b1; tx_ready[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            xc_busy[d] = 0; xc_w[d] = 2; xc_hs[d] = 0; xc_capl[d] = '0; xc_capr[d] = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset zero-inst", {in_ready[0], tx_valid[0], running[0], out_valid[0],
                                  rx_ready[0], ucnt[0], ocnt[0], tx_l[0], tx_r[0]}, 0);
        check("reset hold-inst", {in_ready[1], tx_valid[1], running[1], upulse[1], ucnt[1]}, 0);

        // Prime with two frames, then starve the FIFO.
        clear_logs();
        enable = 1'b1;
        tick();
        push_frame(16'h1111, 16'h2222);
        push_frame(16'h3333, 16'h4444);
        for (int i = 0; i < 30; i++) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("first frame inst%0d", d), log_at(d, 0), 32'h1111_2222);
            check($sformatf("second frame inst%0d", d), log_at(d, 1), 32'h3333_4444);
        end
        check("zero fill frame", log_at(0, 2), 32'h0);
        check("repeat fill frame", log_at(1, 2), 32'h3333_4444);
        drain_to_disabled("plan1");
        check("fill count zero-inst", ucnt[0], 16'(xc_log[0].size() - 2));
        check("fill count hold-inst", ucnt[1], 16'(xc_log[1].size() - 2));

        // Repeat fill of an extreme-valued last frame, plus RX capture/overrun.
        clear_logs();
        enable = 1'b1;
        tick();
        push_frame(16'h0001, 16'h0002);
        push_frame(16'h7FFF, 16'h8000);
        for (int i = 0; i < 30; i++) tick();
        check("hold repeat 1", log_at(1, 2), 32'h7FFF_8000);
        check("hold repeat 2", log_at(1, 3), 32'h7FFF_8000);
        check("zero after extreme", log_at(0, 2), 32'h0);
        out_ready = 1'b0;
        rx_l = 16'hAAAA; rx_r = 16'h5555; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        rx_l = 16'h1234; rx_r = 16'h5678; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("rx overwrite", {out_valid[0], out_l[0], out_r[0], ocnt[0]},
              {1'b1, 16'h1234, 16'h5678, 16'd1});
        rx_l = 16'h0F0F; rx_r = 16'hF0F0; rx_valid = 1'b1; out_ready = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("rx consume+load", {out_valid[1], out_l[1], out_r[1], ocnt[1]},
              {1'b1, 16'h0F0F, 16'hF0F0, 16'd1});
        tick();
        check("rx consumed", out_valid[0], 1'b0);
        out_ready = 1'b0;
        drain_to_disabled("plan2");

        // Muted frames still pop; repeat fill afterwards uses the unmuted head.
        clear_logs();
        enable = 1'b1;
        mute = 1'b1;
        tick();
        push_frame(16'h0100, 16'h0200);
        push_frame(16'h0300, 16'h0400);
        for (int i = 0; i < 60 && (m_fifo[0].size() != 0 || m_fifo[1].size() != 0); i++) tick();
        mute = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("muted frame 1", {log_at(0, 0), log_at(1, 0)}, 64'h0);
        check("muted frame 2", {log_at(0, 1), log_at(1, 1)}, 64'h0);
        check("repeat after mute", log_at(1, 2), 32'h0300_0400);
        drain_to_disabled("mute");

        // Reset in the middle of RUN.
        enable = 1'b1;
        tick();
        push_frame(16'h5555, 16'h6666);
        push_frame(16'h7777, 16'h8888);
        for (int i = 0; i < 6; i++) tick();
        check("running before reset", {running[0], running[1]}, 2'b11);
        rst = 1'b1;
        tick();
        check("mid-run reset", {dut_vec(0), dut_vec(1)}, 0);
        rst = 1'b0;

        // Randomised traffic against the model.
        xc_rand_w = 1;
        for (int c = 0; c < 4000; c++) begin
            int rate;
            rate = ((c / 500) % 2 == 0) ? 50 : 8;
            if ($urandom_range(0, 150) == 0) enable = !enable;
            if ($urandom_range(0, 40) == 0) mute = !mute;
            in_valid = ($urandom_range(0, 99) < rate);
            in_l = 16'($urandom);
            in_r = 16'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            rx_valid = (m_mode[0] != MOff) && (m_mode[1] != MOff) && ($urandom_range(0, 5) == 0);
            rx_l = 16'($urandom);
            rx_r = 16'($urandom);
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
